// File: rtl/dma_mc_pkg.sv
// Shared definitions for the multi-channel DMA: engine state encoding and
// the channel-index width derivation used by every module in the block.
package dma_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_PROCESS = 2'd2,
    ST_DONE    = 2'd3
  } dma_state_t;

  // Channel index width; a single channel still needs one bit of index.
  function automatic int calc_ch_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/dma_mc_engine.sv
// One transfer engine (used for both the read and the write direction):
// arbitrates the channel requests, latches the winner's address/length,
// handshakes the burst start/done with the AXI master and counts beats.
// The caller supplies beat_avail (data or space present for the owner).
module dma_mc_engine
  import dma_mc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CH_W       = calc_ch_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  len_in,
  input  logic                         rcv_start,
  input  logic                         master_done,
  input  logic                         beat_avail,
  output logic                         start,
  output logic [ADDR_WIDTH-1:0]        tgt_addr,
  output logic [LEN_WIDTH-1:0]         tgt_len,
  output logic [CH_W-1:0]              ch,
  output logic                         beat_fire,
  output logic                         beat_last,
  output logic [NUM_CH-1:0]            done
);

  dma_state_t            state;
  dma_state_t            next_state;
  logic                  accept;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_idx;
  logic                  any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [CH_W-1:0]       ch_q;
  // One extra bit so a maximum-length burst counts to len+1 without wrapping.
  logic [LEN_WIDTH:0]    beat_cnt;
  logic [LEN_WIDTH:0]    len_ext;
  logic                  active;
  logic                  all_beats;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // AND-OR mux of the winner's address and length from the one-hot grant.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = sel_len | len_in[i*LEN_WIDTH +: LEN_WIDTH];
      end else begin
        sel_addr = sel_addr;
      end
    end
  end

  assign len_ext   = {1'b0, len_q};
  assign active    = (state == ST_PROCESS) || (state == ST_DONE);
  assign all_beats = (beat_cnt == (len_ext + (LEN_WIDTH+1)'(1)));
  assign beat_fire = active && beat_avail && (beat_cnt <= len_ext);
  assign beat_last = beat_fire && (beat_cnt == len_ext);
  assign start     = (state == ST_START);
  assign tgt_addr  = addr_q;
  assign tgt_len   = len_q;
  assign ch        = ch_q;

  // Next-state logic; the completion pulse fires on the DONE->IDLE cycle.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done       = '0;
    case (state)
      ST_IDLE: begin
        if (any && !master_done) begin
          accept     = 1'b1;
          next_state = ST_START;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_START: begin
        if (rcv_start) begin
          next_state = ST_PROCESS;
        end else begin
          next_state = ST_START;
        end
      end
      ST_PROCESS: begin
        if (master_done) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_PROCESS;
        end
      end
      ST_DONE: begin
        if (!master_done && all_beats) begin
          next_state = ST_IDLE;
          done[ch_q] = 1'b1;
        end else begin
          next_state = ST_DONE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, burst parameters and beat counter; latched only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      ch_q     <= '0;
      beat_cnt <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_q   <= sel_addr;
        len_q    <= sel_len;
        ch_q     <= grant_idx;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + (LEN_WIDTH+1)'(1);
      end else begin
        beat_cnt <= beat_cnt;
      end
    end
  end

endmodule

// File: rtl/dma_mc_rr_arbiter.sv
// Round-robin arbiter: searches from the rotating pointer for the first
// active request and advances the pointer past the winner when accepted.
module rr_arbiter
  import dma_mc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = calc_ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any
);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] idx;

  // Index base+off wrapped into 0..NUM_CH-1 (off never exceeds NUM_CH).
  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) begin
      s = s - NUM_CH;
    end else begin
      s = s;
    end
    return CH_W'(s);
  endfunction

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = wrap_idx(ptr, i);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

  // Pointer moves to the channel after the accepted winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && any) begin
      ptr <= wrap_idx(grant_idx, 1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel DMA front end for one AXI master: an independent read
// engine (drains master2dma FIFO to the owning channel) and write engine
// (moves the owning channel's source data into the dma2master FIFO).
module dma_mc
  import dma_mc_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int CH_W       = calc_ch_w(NUM_CH)
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst,
  input  logic [NUM_CH-1:0]            rd_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  rd_len,
  output logic [NUM_CH-1:0]            rd_done,
  output logic                         rd_data_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [CH_W-1:0]              rd_data_ch,
  output logic                         rd_data_last,
  output logic                         axi_master_read_start,
  input  logic                         axi_master_rcv_read_start,
  input  logic                         axi_master_read_done,
  output logic [ADDR_WIDTH-1:0]        axi_master_target_read_addr,
  output logic [LEN_WIDTH-1:0]         axi_master_target_read_burst_len,
  output logic                         master2dma_afifo_rpull,
  input  logic                         master2dma_afifo_rempty,
  input  logic [DATA_WIDTH-1:0]        master2dma_afifo_rdata,
  input  logic [NUM_CH-1:0]            wr_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  wr_len,
  output logic [NUM_CH-1:0]            wr_done,
  output logic [NUM_CH-1:0]            wr_src_pull,
  input  logic [NUM_CH-1:0]            wr_src_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_src_data,
  output logic                         axi_master_write_start,
  input  logic                         axi_master_rcv_write_start,
  input  logic                         axi_master_write_done,
  output logic [ADDR_WIDTH-1:0]        axi_master_target_write_addr,
  output logic [LEN_WIDTH-1:0]         axi_master_target_write_burst_len,
  output logic                         dma2master_afifo_wpush,
  output logic [DATA_WIDTH-1:0]        dma2master_afifo_wdata,
  input  logic                         dma2master_afifo_wfull
);

  logic            rd_fire;
  logic            rd_last;
  logic [CH_W-1:0] rd_ch;
  logic            wr_fire;
  logic            wr_last;
  logic [CH_W-1:0] wr_ch;
  logic            wr_avail;

  dma_mc_engine #(
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .CH_W       (CH_W)
  ) u_rd (
    .clk         (cpu_clk),
    .rst         (cpu_rst),
    .req         (rd_req),
    .addr_in     (rd_addr),
    .len_in      (rd_len),
    .rcv_start   (axi_master_rcv_read_start),
    .master_done (axi_master_read_done),
    .beat_avail  (!master2dma_afifo_rempty),
    .start       (axi_master_read_start),
    .tgt_addr    (axi_master_target_read_addr),
    .tgt_len     (axi_master_target_read_burst_len),
    .ch          (rd_ch),
    .beat_fire   (rd_fire),
    .beat_last   (rd_last),
    .done        (rd_done)
  );

  // A write beat needs both FIFO space and data in the owner's source.
  assign wr_avail = !dma2master_afifo_wfull && !wr_src_empty[wr_ch];

  dma_mc_engine #(
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .CH_W       (CH_W)
  ) u_wr (
    .clk         (cpu_clk),
    .rst         (cpu_rst),
    .req         (wr_req),
    .addr_in     (wr_addr),
    .len_in      (wr_len),
    .rcv_start   (axi_master_rcv_write_start),
    .master_done (axi_master_write_done),
    .beat_avail  (wr_avail),
    .start       (axi_master_write_start),
    .tgt_addr    (axi_master_target_write_addr),
    .tgt_len     (axi_master_target_write_burst_len),
    .ch          (wr_ch),
    .beat_fire   (wr_fire),
    .beat_last   (wr_last),
    .done        (wr_done)
  );

  // Read beats pass straight from the FIFO; data is zeroed between beats.
  assign master2dma_afifo_rpull = rd_fire;
  assign rd_data_valid          = rd_fire;
  assign rd_data                = rd_fire ? master2dma_afifo_rdata : '0;
  assign rd_data_ch             = rd_ch;
  assign rd_data_last           = rd_last;

  // Write beats pop only the owner's source buffer.
  assign wr_src_pull            = wr_fire ? (NUM_CH'(1) << wr_ch) : '0;
  assign dma2master_afifo_wpush = wr_fire;
  assign dma2master_afifo_wdata = wr_fire ? wr_src_data[wr_ch*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_dma_mc.sv
// Directed bench for dma_mc: table of read bursts plus hand-written
// arbitration, write-throttling and mid-burst reset sequences.
module tb_dma_mc;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CW = 1;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst;
  logic [NC-1:0]    rd_req;
  logic [NC*AW-1:0] rd_addr;
  logic [NC*LW-1:0] rd_len;
  logic [NC-1:0]    rd_done;
  logic             rd_data_valid;
  logic [DW-1:0]    rd_data;
  logic [CW-1:0]    rd_data_ch;
  logic             rd_data_last;
  logic             axi_master_read_start;
  logic             axi_master_rcv_read_start;
  logic             axi_master_read_done;
  logic [AW-1:0]    axi_master_target_read_addr;
  logic [LW-1:0]    axi_master_target_read_burst_len;
  logic             master2dma_afifo_rpull;
  logic             master2dma_afifo_rempty;
  logic [DW-1:0]    master2dma_afifo_rdata;
  logic [NC-1:0]    wr_req;
  logic [NC*AW-1:0] wr_addr;
  logic [NC*LW-1:0] wr_len;
  logic [NC-1:0]    wr_done;
  logic [NC-1:0]    wr_src_pull;
  logic [NC-1:0]    wr_src_empty;
  logic [NC*DW-1:0] wr_src_data;
  logic             axi_master_write_start;
  logic             axi_master_rcv_write_start;
  logic             axi_master_write_done;
  logic [AW-1:0]    axi_master_target_write_addr;
  logic [LW-1:0]    axi_master_target_write_burst_len;
  logic             dma2master_afifo_wpush;
  logic [DW-1:0]    dma2master_afifo_wdata;
  logic             dma2master_afifo_wfull;

  always #5 cpu_clk = ~cpu_clk;

  dma_mc #(.NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_done(rd_done),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_ch(rd_data_ch),
    .rd_data_last(rd_data_last), .axi_master_read_start(axi_master_read_start),
    .axi_master_rcv_read_start(axi_master_rcv_read_start),
    .axi_master_read_done(axi_master_read_done),
    .axi_master_target_read_addr(axi_master_target_read_addr),
    .axi_master_target_read_burst_len(axi_master_target_read_burst_len),
    .master2dma_afifo_rpull(master2dma_afifo_rpull),
    .master2dma_afifo_rempty(master2dma_afifo_rempty),
    .master2dma_afifo_rdata(master2dma_afifo_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_done(wr_done),
    .wr_src_pull(wr_src_pull), .wr_src_empty(wr_src_empty), .wr_src_data(wr_src_data),
    .axi_master_write_start(axi_master_write_start),
    .axi_master_rcv_write_start(axi_master_rcv_write_start),
    .axi_master_write_done(axi_master_write_done),
    .axi_master_target_write_addr(axi_master_target_write_addr),
    .axi_master_target_write_burst_len(axi_master_target_write_burst_len),
    .dma2master_afifo_wpush(dma2master_afifo_wpush),
    .dma2master_afifo_wdata(dma2master_afifo_wdata),
    .dma2master_afifo_wfull(dma2master_afifo_wfull)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    int          len;
    int          pre;
    int          post;
    bit          early;
    int          exp_beats;
    int          exp_left;
  } rd_vec_t;

  rd_vec_t vecs[6];

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] src0_q[$];
  logic [DW-1:0] src1_q[$];
  logic [DW-1:0] rd_dat_log[$];
  int            rd_ch_log[$];
  bit            rd_last_log[$];
  logic [DW-1:0] wr_log[$];
  int            rd_done_cnt, wr_done_cnt, rd_start_cnt, wr_start_cnt, rd_run, wr_run;
  logic [NC-1:0] rd_done_seen, wr_done_seen;
  int            full_push_viol, pull_ch0, empty_pull_viol;
  bit            wfull_toggle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic outs_or();
    return |{rd_done, rd_data_valid, rd_data, rd_data_ch, rd_data_last, axi_master_read_start,
             axi_master_target_read_addr, axi_master_target_read_burst_len, master2dma_afifo_rpull,
             wr_done, wr_src_pull, axi_master_write_start, axi_master_target_write_addr,
             axi_master_target_write_burst_len, dma2master_afifo_wpush, dma2master_afifo_wdata};
  endfunction

  task automatic refresh();
    master2dma_afifo_rempty = (fifo_q.size() == 0);
    master2dma_afifo_rdata = '0;
    if (fifo_q.size() > 0) master2dma_afifo_rdata = fifo_q[0];
    wr_src_empty = {src1_q.size() == 0, src0_q.size() == 0};
    wr_src_data = '0;
    if (src0_q.size() > 0) wr_src_data[0 +: DW] = src0_q[0];
    if (src1_q.size() > 0) wr_src_data[DW +: DW] = src1_q[0];
  endtask

  task automatic clear_logs();
    rd_dat_log.delete(); rd_ch_log.delete(); rd_last_log.delete(); wr_log.delete();
    rd_done_cnt = 0; wr_done_cnt = 0; rd_start_cnt = 0; wr_start_cnt = 0;
    rd_done_seen = '0; wr_done_seen = '0;
    full_push_viol = 0; pull_ch0 = 0; empty_pull_viol = 0;
  endtask

  // One clock: observe at the falling edge, update models just after the rising edge.
  task automatic cyc();
    logic s_rpull, s_rstart, s_wstart;
    logic [NC-1:0] s_wpull;
    @(negedge cpu_clk);
    s_rpull = master2dma_afifo_rpull;
    s_wpull = wr_src_pull;
    s_rstart = axi_master_read_start;
    s_wstart = axi_master_write_start;
    if (rd_data_valid) begin
      rd_dat_log.push_back(rd_data);
      rd_ch_log.push_back(int'(rd_data_ch));
      rd_last_log.push_back(rd_data_last);
    end
    if (dma2master_afifo_wpush) begin
      wr_log.push_back(dma2master_afifo_wdata);
      if (dma2master_afifo_wfull) full_push_viol++;
    end
    if (wr_src_pull[0]) pull_ch0++;
    if (s_rpull && fifo_q.size() == 0) empty_pull_viol++;
    if (|rd_done) begin rd_done_cnt++; rd_done_seen = rd_done_seen | rd_done; end
    if (|wr_done) begin wr_done_cnt++; wr_done_seen = wr_done_seen | wr_done; end
    if (s_rstart) begin rd_start_cnt++; rd_run++; end else rd_run = 0;
    if (s_wstart) begin wr_start_cnt++; wr_run++; end else wr_run = 0;
    @(posedge cpu_clk);
    #1;
    if (s_rpull && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (s_wpull[0] && src0_q.size() > 0) void'(src0_q.pop_front());
    if (s_wpull[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    // Master accepts a start after seeing it for three cycles.
    axi_master_rcv_read_start = s_rstart && (rd_run >= 3);
    axi_master_rcv_write_start = s_wstart && (wr_run >= 3);
    if (wfull_toggle) dma2master_afifo_wfull = ~dma2master_afifo_wfull;
    refresh();
  endtask

  task automatic rd_burst(input rd_vec_t v, input int r);
    int n, tgt, derr, lastc;
    clear_logs();
    for (int i = 0; i < v.pre; i++) fifo_q.push_back(v.addr + 32'(i));
    rd_addr[v.ch*AW +: AW] = v.addr;
    rd_len[v.ch*LW +: LW] = LW'(v.len);
    refresh();
    rd_req[v.ch] = 1'b1;
    for (n = 0; n < 20 && rd_start_cnt == 0; n++) cyc();
    check($sformatf("r%0d_start_seen", r), rd_start_cnt > 0, 1'b1);
    check($sformatf("r%0d_tgt_addr", r), axi_master_target_read_addr, v.addr);
    check($sformatf("r%0d_tgt_len", r), axi_master_target_read_burst_len, v.len);
    tgt = v.early ? v.pre : v.exp_beats;
    for (n = 0; n < 400 && rd_dat_log.size() < tgt; n++) cyc();
    if (v.early) begin
      axi_master_read_done = 1'b1;
      cyc(); cyc();
      axi_master_read_done = 1'b0;
      cyc(); cyc(); cyc();
      check($sformatf("r%0d_no_early_done", r), rd_done_cnt, 0);
      for (int i = 0; i < v.post; i++) fifo_q.push_back(v.addr + 32'(v.pre + i));
      refresh();
    end else begin
      cyc();
      axi_master_read_done = 1'b1;
      cyc(); cyc();
      axi_master_read_done = 1'b0;
    end
    for (n = 0; n < 10 && rd_done_cnt == 0; n++) cyc();
    rd_req[v.ch] = 1'b0;
    check($sformatf("r%0d_done_latency", r), n, v.early ? 2 : 1);
    cyc(); cyc(); cyc();
    derr = 0; lastc = 0;
    for (int i = 0; i < rd_dat_log.size(); i++) begin
      if (rd_dat_log[i] !== v.addr + 32'(i)) derr++;
      if (rd_ch_log[i] != v.ch) derr++;
      if (rd_last_log[i] != (i == v.len)) derr++;
      if (rd_last_log[i]) lastc++;
    end
    check($sformatf("r%0d_beats", r), rd_dat_log.size(), v.exp_beats);
    check($sformatf("r%0d_data_ch_last", r), derr, 0);
    check($sformatf("r%0d_last_count", r), lastc, 1);
    check($sformatf("r%0d_fifo_left", r), fifo_q.size(), v.exp_left);
    check($sformatf("r%0d_done_count", r), rd_done_cnt, 1);
    check($sformatf("r%0d_done_vec", r), rd_done_seen, 2'b01 << v.ch);
    check($sformatf("r%0d_start_cycles", r), rd_start_cnt, 4);
    check($sformatf("r%0d_empty_pull", r), empty_pull_viol, 0);
    fifo_q.delete();
    refresh();
  endtask

  // One len=0 read burst served while rd_req stays as set by the caller.
  task automatic serve_one(input int exp_ch, input logic [NC-1:0] drop, input int k);
    int n;
    clear_logs();
    fifo_q.push_back(32'hC0DE_0000 + 32'(k));
    refresh();
    for (n = 0; n < 30 && rd_dat_log.size() < 1; n++) cyc();
    check($sformatf("arb%0d_beat", k), rd_dat_log.size(), 1);
    if (rd_dat_log.size() > 0) check($sformatf("arb%0d_owner", k), rd_ch_log[0], exp_ch);
    axi_master_read_done = 1'b1;
    cyc(); cyc();
    axi_master_read_done = 1'b0;
    for (n = 0; n < 10 && rd_done_cnt == 0; n++) cyc();
    rd_req = rd_req & ~drop;
    check($sformatf("arb%0d_done_vec", k), rd_done_seen, 2'b01 << exp_ch);
  endtask

  initial begin
    int n, derr;
    cpu_rst = 1'b1;
    rd_req = '0; rd_addr = '0; rd_len = '0;
    wr_req = '0; wr_addr = '0; wr_len = '0;
    axi_master_rcv_read_start = 1'b0; axi_master_read_done = 1'b0;
    axi_master_rcv_write_start = 1'b0; axi_master_write_done = 1'b0;
    dma2master_afifo_wfull = 1'b0; wfull_toggle = 1'b0;
    rd_run = 0; wr_run = 0;
    clear_logs();
    refresh();
    repeat (3) cyc();
    check("reset_outputs_zero", outs_or(), 1'b0);
    cpu_rst = 1'b0;
    cyc();

    //          ch  addr           len  pre  post early beats left
    vecs[0] = '{0, 32'h0000_1000,   3,   4,   0,  1'b0,  4,   0};
    vecs[1] = '{1, 32'h0000_2040,   0,   1,   0,  1'b0,  1,   0};
    vecs[2] = '{0, 32'h0000_3000,   3,   6,   0,  1'b0,  4,   2};
    vecs[3] = '{1, 32'h0000_4000,   3,   3,   1,  1'b1,  4,   0};
    vecs[4] = '{0, 32'h0000_5000,  15,  16,   0,  1'b0, 16,   0};
    vecs[5] = '{1, 32'h0000_7000, 255, 256,   0,  1'b0, 256,  0};
    for (int r = 0; r < 6; r++) rd_burst(vecs[r], r);

    // Round robin: both held -> ch0, ch1 (ch0 still held), then ch0 again.
    rd_len = '0;
    rd_req = 2'b11;
    serve_one(0, 2'b00, 0);
    serve_one(1, 2'b10, 1);
    serve_one(0, 2'b01, 2);
    clear_logs();
    cyc(); cyc(); cyc();
    check("arb_no_regrant", rd_start_cnt, 0);

    // Write burst on ch1, len=7, FIFO full every other cycle.
    clear_logs();
    for (int i = 0; i < 8; i++) src1_q.push_back(32'h0000_00A0 + 32'(i));
    wr_addr[AW +: AW] = 32'h0000_8000;
    wr_len[LW +: LW] = 8'd7;
    wfull_toggle = 1'b1;
    refresh();
    wr_req = 2'b10;
    for (n = 0; n < 20 && wr_start_cnt == 0; n++) cyc();
    check("wr_tgt_addr", axi_master_target_write_addr, 32'h0000_8000);
    check("wr_tgt_len", axi_master_target_write_burst_len, 8'd7);
    for (n = 0; n < 100 && wr_log.size() < 8; n++) cyc();
    axi_master_write_done = 1'b1;
    cyc(); cyc();
    axi_master_write_done = 1'b0;
    for (n = 0; n < 10 && wr_done_cnt == 0; n++) cyc();
    wr_req = '0;
    wfull_toggle = 1'b0;
    dma2master_afifo_wfull = 1'b0;
    cyc(); cyc(); cyc();
    derr = 0;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 32'h0000_00A0 + 32'(i)) derr++;
    check("wr_push_count", wr_log.size(), 8);
    check("wr_data_order", derr, 0);
    check("wr_push_while_full", full_push_viol, 0);
    check("wr_pull_wrong_ch", pull_ch0, 0);
    check("wr_done_count", wr_done_cnt, 1);
    check("wr_done_vec", wr_done_seen, 2'b10);
    check("wr_start_cycles", wr_start_cnt, 4);

    // Reset in the middle of a read burst and a write burst.
    clear_logs();
    rd_addr[0 +: AW] = 32'h0000_9000; rd_len[0 +: LW] = 8'd3;
    wr_addr[AW +: AW] = 32'h0000_B000; wr_len[LW +: LW] = 8'd3;
    fifo_q.push_back(32'h0000_00D0);
    src1_q.push_back(32'h0000_00D1);
    refresh();
    rd_req = 2'b01; wr_req = 2'b10;
    for (n = 0; n < 60 && (rd_dat_log.size() < 1 || wr_log.size() < 1); n++) cyc();
    check("rst_mid_progress", (rd_dat_log.size() >= 1) && (wr_log.size() >= 1), 1'b1);
    cpu_rst = 1'b1;
    cyc();
    check("rst_mid_outputs_zero", outs_or(), 1'b0);
    cyc();
    cpu_rst = 1'b0;
    check("rst_mid_no_done", rd_done_cnt + wr_done_cnt, 0);
    fifo_q.delete(); src1_q.delete();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(32'h0000_00E0 + 32'(i));
      src1_q.push_back(32'h0000_00F0 + 32'(i));
    end
    refresh();
    for (n = 0; n < 80 && (rd_dat_log.size() < 4 || wr_log.size() < 4); n++) cyc();
    check("rst_regrant_rd_addr", axi_master_target_read_addr, 32'h0000_9000);
    check("rst_regrant_wr_addr", axi_master_target_write_addr, 32'h0000_B000);
    axi_master_read_done = 1'b1; axi_master_write_done = 1'b1;
    cyc(); cyc();
    axi_master_read_done = 1'b0; axi_master_write_done = 1'b0;
    for (n = 0; n < 10 && (rd_done_cnt == 0 || wr_done_cnt == 0); n++) begin
      cyc();
      if (rd_done_cnt > 0) rd_req = '0;
      if (wr_done_cnt > 0) wr_req = '0;
    end
    rd_req = '0; wr_req = '0;
    cyc(); cyc(); cyc();
    derr = 0;
    for (int i = 0; i < rd_dat_log.size(); i++) if (rd_dat_log[i] !== 32'h0000_00E0 + 32'(i)) derr++;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 32'h0000_00F0 + 32'(i)) derr++;
    check("rst_fresh_rd_beats", rd_dat_log.size(), 4);
    check("rst_fresh_wr_beats", wr_log.size(), 4);
    check("rst_fresh_data", derr, 0);
    check("rst_fresh_rd_done", rd_done_seen, 2'b01);
    check("rst_fresh_wr_done", wr_done_seen, 2'b10);
    check("rst_fresh_done_counts", rd_done_cnt + wr_done_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
